// File: rtl/timer_pkg.sv
// Shared register map and CTRL field layout for the multi-channel timer.
package timer_pkg;

    // Per-channel register offsets (low two bits of the word address)
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // CTRL bit positions
    localparam int unsigned CTRL_EN        = 0;
    localparam int unsigned CTRL_MODE      = 1;
    localparam int unsigned CTRL_IE        = 2;
    localparam int unsigned CTRL_PRESC_LSB = 8;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // Widest prescaler field the CTRL word can carry
    localparam int unsigned PRESC_MAX_W = 16;

    // Assemble a CTRL read word; bits not driven read as zero.
    function automatic logic [31:0] pack_ctrl(input logic en, input logic mode, input logic ie,
                                              input logic [PRESC_MAX_W-1:0] presc);
        logic [31:0] w;
        w                                = '0;
        w[CTRL_EN]                       = en;
        w[CTRL_MODE]                     = mode;
        w[CTRL_IE]                       = ie;
        w[CTRL_PRESC_LSB +: PRESC_MAX_W] = presc;
        return w;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/LOAD registers, prescaler, counter, sticky pending flag and IRQ.
module timer_channel
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned PRESC_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               wr_ctrl_i,
    input  logic               wr_load_i,
    input  logic               wr_status_i,
    input  logic [31:0]        wdata_i,
    output logic               en_o,
    output logic               mode_o,
    output logic               ie_o,
    output logic [PRESC_W-1:0] presc_o,
    output logic [WIDTH-1:0]   load_o,
    output logic [WIDTH-1:0]   count_o,
    output logic               pend_o,
    output logic               irq_o
);

    logic               en_q, en_d;
    logic               mode_q, mode_d;
    logic               ie_q, ie_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [WIDTH-1:0]   load_q, load_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic               pend_q, pend_d;
    logic               irq_q, irq_d;
    logic               tick, fire, restart;

    // Only a few CTRL bits and the LOAD field are meaningful
    logic unused_wdata;
    assign unused_wdata = ^wdata_i;

    // Next-state: prescale/count, one-shot disable, bus writes, then pending set/clear
    always_comb begin
        en_d    = en_q;
        mode_d  = mode_q;
        ie_d    = ie_q;
        presc_d = presc_q;
        load_d  = load_q;
        count_d = count_q;
        pcnt_d  = pcnt_q;
        pend_d  = pend_q;

        tick = en_q && (pcnt_q == presc_q);
        // LOAD=0 never fires and keeps COUNT at 0
        fire = tick && (load_q != '0) && (count_q == load_q - WIDTH'(1));

        if (en_q) begin
            pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);
        end
        if (tick && (load_q != '0)) begin
            count_d = fire ? '0 : count_q + WIDTH'(1);
        end
        if (fire && (mode_q == MODE_ONESHOT)) begin
            en_d = 1'b0;
        end

        restart = wr_load_i || (wr_ctrl_i && wdata_i[CTRL_EN] && !en_q);
        if (wr_ctrl_i) begin
            en_d    = wdata_i[CTRL_EN];
            mode_d  = wdata_i[CTRL_MODE];
            ie_d    = wdata_i[CTRL_IE];
            presc_d = wdata_i[CTRL_PRESC_LSB +: PRESC_W];
        end
        if (wr_load_i) begin
            load_d = wdata_i[WIDTH-1:0];
        end
        if (restart) begin
            count_d = '0;
            pcnt_d  = '0;
        end

        // A fire in the same cycle as a W1C leaves PEND set
        if (wr_status_i && wdata_i[0]) begin
            pend_d = 1'b0;
        end
        if (fire) begin
            pend_d = 1'b1;
        end

        irq_d = pend_q && ie_q;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            en_q    <= 1'b0;
            mode_q  <= MODE_PERIODIC;
            ie_q    <= 1'b0;
            presc_q <= '0;
            load_q  <= '0;
            count_q <= '0;
            pcnt_q  <= '0;
            pend_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            en_q    <= en_d;
            mode_q  <= mode_d;
            ie_q    <= ie_d;
            presc_q <= presc_d;
            load_q  <= load_d;
            count_q <= count_d;
            pcnt_q  <= pcnt_d;
            pend_q  <= pend_d;
            irq_q   <= irq_d;
        end
    end

    assign en_o    = en_q;
    assign mode_o  = mode_q;
    assign ie_o    = ie_q;
    assign presc_o = presc_q;
    assign load_o  = load_q;
    assign count_o = count_q;
    assign pend_o  = pend_q;
    assign irq_o   = irq_q;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel timer: bus decode, registered read mux, grant and IRQ OR-reduction.
module multi_timer
    import timer_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned PRESC_W = 8,
    localparam int unsigned AW     = $clog2(NUM_CH) + 2
) (
    input  logic              i_CLK,
    input  logic              i_RSTn,
    input  logic              i_CE,
    input  logic              i_REQ,
    input  logic              i_WE,
    input  logic [AW-1:0]     i_ADDR,
    input  logic [31:0]       i_WDATA,
    output logic [31:0]       o_RDATA,
    output logic              o_GNT,
    output logic [NUM_CH-1:0] o_IRQ,
    output logic              o_IRQ_ANY
);

    logic [1:0]  reg_sel;
    logic [3:0]  ch_sel;
    logic        wr_acc, rd_acc;
    logic [31:0] rd_word;
    logic [31:0] rdata_q;

    logic [NUM_CH-1:0]  en_w, mode_w, ie_w, pend_w, irq_w;
    logic [NUM_CH-1:0]  wr_ctrl, wr_load, wr_status;
    logic [PRESC_W-1:0] presc_w [NUM_CH];
    logic [WIDTH-1:0]   load_w  [NUM_CH];
    logic [WIDTH-1:0]   count_w [NUM_CH];

    assign reg_sel = i_ADDR[1:0];

    if (NUM_CH > 1) begin : g_ch_sel
        assign ch_sel = 4'(i_ADDR[AW-1:2]);
    end else begin : g_ch_sel_one
        assign ch_sel = '0;
    end

    assign o_GNT  = i_REQ & i_CE;
    assign wr_acc = o_GNT & i_WE;
    assign rd_acc = o_GNT & ~i_WE;

    // Channel indices at or above NUM_CH match no instance, so such writes drop out here
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign wr_ctrl[c]   = wr_acc && (ch_sel == 4'(c)) && (reg_sel == REG_CTRL);
        assign wr_load[c]   = wr_acc && (ch_sel == 4'(c)) && (reg_sel == REG_LOAD);
        assign wr_status[c] = wr_acc && (ch_sel == 4'(c)) && (reg_sel == REG_STATUS);

        timer_channel #(
            .WIDTH   (WIDTH),
            .PRESC_W (PRESC_W)
        ) u_ch (
            .clk_i       (i_CLK),
            .rst_ni      (i_RSTn),
            .wr_ctrl_i   (wr_ctrl[c]),
            .wr_load_i   (wr_load[c]),
            .wr_status_i (wr_status[c]),
            .wdata_i     (i_WDATA),
            .en_o        (en_w[c]),
            .mode_o      (mode_w[c]),
            .ie_o        (ie_w[c]),
            .presc_o     (presc_w[c]),
            .load_o      (load_w[c]),
            .count_o     (count_w[c]),
            .pend_o      (pend_w[c]),
            .irq_o       (irq_w[c])
        );
    end

    // Read mux; unmatched channel indices fall through to zero
    always_comb begin
        rd_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel == 4'(c)) begin
                unique case (reg_sel)
                    REG_CTRL:   rd_word = pack_ctrl(en_w[c], mode_w[c], ie_w[c],
                                                    PRESC_MAX_W'(presc_w[c]));
                    REG_LOAD:   rd_word = 32'(load_w[c]);
                    REG_COUNT:  rd_word = 32'(count_w[c]);
                    REG_STATUS: rd_word = {31'd0, pend_w[c]};
                    default:    rd_word = '0;
                endcase
            end
        end
    end

    // Read data register, held until the next accepted read
    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            rdata_q <= '0;
        end else if (rd_acc) begin
            rdata_q <= rd_word;
        end
    end

    assign o_RDATA   = rdata_q;
    assign o_IRQ     = irq_w;
    assign o_IRQ_ANY = |irq_w;

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer; reads are checked by a queue-based monitor.
module tb_multi_timer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req, we, ce4, ce5;
    logic [3:0]  addr4;
    logic [4:0]  addr5;
    logic [31:0] wdata;

    logic [31:0] rdata4, rdata5;
    logic        gnt4, gnt5, any4, any5;
    logic [3:0]  irq4;
    logic [4:0]  irq5;

    int n_cmp = 0;
    int n_err = 0;

    // bit 32 selects which DUT the expected read data belongs to
    logic [32:0] exp_q [$];
    string       name_q [$];
    bit          rd_v4 = 1'b0;
    bit          rd_v5 = 1'b0;

    always #5 clk = ~clk;

    multi_timer #(
        .NUM_CH  (4),
        .WIDTH   (32),
        .PRESC_W (8)
    ) u_dut (
        .i_CLK     (clk),
        .i_RSTn    (rstn),
        .i_CE      (ce4),
        .i_REQ     (req),
        .i_WE      (we),
        .i_ADDR    (addr4),
        .i_WDATA   (wdata),
        .o_RDATA   (rdata4),
        .o_GNT     (gnt4),
        .o_IRQ     (irq4),
        .o_IRQ_ANY (any4)
    );

    // Non-power-of-two channel count so out-of-range indices are addressable
    multi_timer #(
        .NUM_CH  (5),
        .WIDTH   (16),
        .PRESC_W (4)
    ) u_dut5 (
        .i_CLK     (clk),
        .i_RSTn    (rstn),
        .i_CE      (ce5),
        .i_REQ     (req),
        .i_WE      (we),
        .i_ADDR    (addr5),
        .i_WDATA   (wdata),
        .o_RDATA   (rdata5),
        .o_GNT     (gnt5),
        .o_IRQ     (irq5),
        .o_IRQ_ANY (any5)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: a read accepted at a posedge is compared at the following negedge
    always @(posedge clk) begin
        rd_v4 <= req & ce4 & ~we;
        rd_v5 <= req & ce5 & ~we;
    end

    always @(negedge clk) begin
        logic [32:0] e;
        string       nm;
        logic [31:0] act;
        if (rd_v4 || rd_v5) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_read: got 0x%08h, expected no read", rdata4);
            end else begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = e[32] ? rdata5 : rdata4;
                if (act !== e[31:0]) begin
                    n_err++;
                    $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, e[31:0]);
                end
            end
        end
    end

    // All bus tasks are entered at a negedge and return at the next negedge
    task automatic bus_wr(input bit sel, input logic [4:0] a, input logic [31:0] d);
        req   = 1'b1;
        we    = 1'b1;
        wdata = d;
        addr4 = a[3:0];
        addr5 = a;
        ce4   = ~sel;
        ce5   = sel;
        @(negedge clk);
        req = 1'b0;
        we  = 1'b0;
        ce4 = 1'b0;
        ce5 = 1'b0;
    endtask

    task automatic bus_rd(input bit sel, input logic [4:0] a, input logic [31:0] exp,
                          input string nm);
        req   = 1'b1;
        we    = 1'b0;
        addr4 = a[3:0];
        addr5 = a;
        ce4   = ~sel;
        ce5   = sel;
        exp_q.push_back({sel, exp});
        name_q.push_back(nm);
        #1;
        chk({nm, "_gnt"}, {31'd0, sel ? gnt5 : gnt4}, 32'd1);
        @(negedge clk);
        req = 1'b0;
        ce4 = 1'b0;
        ce5 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1);
    end

    initial begin
        rstn  = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        ce4   = 1'b0;
        ce5   = 1'b0;
        addr4 = '0;
        addr5 = '0;
        wdata = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Reset state
        chk("rst_irq", {28'd0, irq4}, 32'd0);
        chk("rst_irq_any", {31'd0, any4}, 32'd0);
        for (int i = 0; i < 16; i++) bus_rd(0, 5'(i), 32'd0, $sformatf("rst_word%0d", i));

        // Ch0 periodic, LOAD=5, PRESC=0
        bus_wr(0, 5'd1, 32'd5);
        bus_wr(0, 5'd0, 32'h5);
        for (int k = 0; k < 5; k++) bus_rd(0, 5'd2, 32'(k), $sformatf("ch0_count%0d", k));
        chk("ch0_irq_lag", {28'd0, irq4}, 32'd0);
        bus_rd(0, 5'd3, 32'd1, "ch0_pend");
        chk("ch0_irq", {28'd0, irq4}, 32'd1);
        chk("ch0_irq_any", {31'd0, any4}, 32'd1);
        bus_rd(0, 5'd2, 32'd1, "ch0_count_wrap");
        bus_wr(0, 5'd3, 32'd1);
        bus_rd(0, 5'd3, 32'd0, "ch0_w1c_a");
        bus_rd(0, 5'd3, 32'd0, "ch0_w1c_b");
        bus_rd(0, 5'd3, 32'd1, "ch0_refire");
        // Disable with IE=0: IRQ drops one cycle later, PEND and COUNT are kept
        bus_wr(0, 5'd0, 32'd0);
        chk("ch0_irq_hold", {28'd0, irq4}, 32'd1);
        bus_rd(0, 5'd2, 32'd2, "ch0_count_frz");
        chk("ch0_irq_drop", {28'd0, irq4}, 32'd0);
        bus_rd(0, 5'd3, 32'd1, "ch0_pend_kept");
        idle(3);
        bus_rd(0, 5'd2, 32'd2, "ch0_count_frz2");
        bus_rd(0, 5'd0, 32'd0, "ch0_ctrl");
        bus_rd(0, 5'd1, 32'd5, "ch0_load");
        bus_wr(0, 5'd3, 32'd1);
        bus_rd(0, 5'd3, 32'd0, "ch0_pend_clr");

        // Ch1 one-shot, LOAD=3, PRESC=3: single fire 12 cycles after enable
        bus_wr(0, 5'd5, 32'd3);
        bus_wr(0, 5'd4, 32'h307);
        idle(11);
        bus_rd(0, 5'd7, 32'd0, "ch1_pre_fire");
        chk("ch1_irq_lag", {28'd0, irq4}, 32'd0);
        bus_rd(0, 5'd7, 32'd1, "ch1_pend");
        chk("ch1_irq", {28'd0, irq4}, 32'h2);
        bus_rd(0, 5'd4, 32'h306, "ch1_ctrl_en_off");
        bus_rd(0, 5'd6, 32'd0, "ch1_count");
        bus_wr(0, 5'd7, 32'd1);
        idle(20);
        bus_rd(0, 5'd7, 32'd0, "ch1_no_refire");
        bus_rd(0, 5'd6, 32'd0, "ch1_count_hold");

        // Ch2: W1C in the same cycle as a fire leaves PEND set
        bus_wr(0, 5'd9, 32'd4);
        bus_wr(0, 5'd8, 32'h5);
        idle(7);
        bus_wr(0, 5'd11, 32'd1);
        bus_rd(0, 5'd11, 32'd1, "ch2_set_wins");
        bus_wr(0, 5'd8, 32'h4);
        bus_wr(0, 5'd11, 32'd1);
        chk("ch2_irq_hold", {28'd0, irq4}, 32'h4);
        idle(1);
        chk("ch2_irq_drop", {28'd0, irq4}, 32'd0);
        bus_rd(0, 5'd11, 32'd0, "ch2_pend_clr");
        // EN 0->1 restarts COUNT from the frozen value 2
        bus_wr(0, 5'd8, 32'h1);
        bus_rd(0, 5'd10, 32'd0, "ch2_restart");
        bus_wr(0, 5'd8, 32'd0);

        // Ch3: LOAD=0 never fires, then LOAD=2 restarts and fires
        bus_wr(0, 5'd12, 32'h5);
        idle(100);
        bus_rd(0, 5'd15, 32'd0, "ch3_load0_pend");
        bus_rd(0, 5'd14, 32'd0, "ch3_load0_count");
        bus_wr(0, 5'd13, 32'd2);
        bus_rd(0, 5'd14, 32'd0, "ch3_count0");
        bus_rd(0, 5'd14, 32'd1, "ch3_count1");
        bus_rd(0, 5'd15, 32'd1, "ch3_pend");
        chk("ch3_irq", {28'd0, irq4}, 32'h8);

        // Reset pulse with ch0 at COUNT=3
        bus_wr(0, 5'd0, 32'h1);
        idle(3);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("rst2_rdata", rdata4, 32'd0);
        chk("rst2_irq", {28'd0, irq4}, 32'd0);
        chk("rst2_irq_any", {31'd0, any4}, 32'd0);
        for (int i = 0; i < 16; i++) bus_rd(0, 5'(i), 32'd0, $sformatf("rst2_word%0d", i));
        bus_wr(0, 5'd2, 32'd7);
        bus_rd(0, 5'd2, 32'd0, "count_ro");

        // Five-channel instance: channel 4 valid, channels 5..7 out of range
        bus_wr(1, 5'd17, 32'h1234);
        bus_rd(1, 5'd17, 32'h1234, "ch4_load");
        bus_wr(1, 5'd21, 32'hBEEF);
        bus_rd(1, 5'd21, 32'd0, "ch5_load");
        bus_rd(1, 5'd29, 32'd0, "ch7_load");
        bus_rd(1, 5'd17, 32'h1234, "ch4_load_kept");
        req = 1'b1;
        #1;
        chk("gnt_no_ce4", {31'd0, gnt4}, 32'd0);
        chk("gnt_no_ce5", {31'd0, gnt5}, 32'd0);
        @(negedge clk);
        req = 1'b0;

        idle(2);
        chk("reads_drained", 32'(exp_q.size()), 32'd0);
        chk("dut5_irq", {26'd0, any5, irq5}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
